// File: rtl/mp_ooo_dp_sram_init_pkg.sv
// Shared types and helpers for the out-of-order core two-port SRAM model.
package mp_ooo_sram_pkg;

    localparam int SRAM_MAX_W = 64;

    typedef enum logic {SRAM_INIT, SRAM_RUN} sram_init_state_t;

    // Lane i of the mask covers bits [i*gran +: gran]; bits beyond the real width come out 0.
    function automatic logic [SRAM_MAX_W-1:0] expand_wmask(input logic [SRAM_MAX_W-1:0] mask,
                                                           input int gran);
        logic [SRAM_MAX_W-1:0] r_bits;
        r_bits = '0;
        for (int i = 0; i < SRAM_MAX_W; i++)
            r_bits[i] = mask[i / gran];
        return r_bits;
    endfunction

endpackage

// File: rtl/mp_ooo_dp_sram_init_wmerge.sv
// Combinational merge of up to two masked writes onto an old word; port 1 wins shared lanes.
module mp_ooo_sram_wmerge #(
    parameter int DATA_WIDTH = 2
) (
    input  logic [DATA_WIDTH-1:0] i_old,
    input  logic [DATA_WIDTH-1:0] i_d0,
    input  logic [DATA_WIDTH-1:0] i_m0,
    input  logic                  i_en0,
    input  logic [DATA_WIDTH-1:0] i_d1,
    input  logic [DATA_WIDTH-1:0] i_m1,
    input  logic                  i_en1,
    output logic [DATA_WIDTH-1:0] o_new
);

    logic [DATA_WIDTH-1:0] w_m0;
    logic [DATA_WIDTH-1:0] w_m1;

    assign w_m0  = i_en0 ? i_m0 : '0;
    assign w_m1  = i_en1 ? i_m1 : '0;
    assign o_new = (i_old & ~w_m0 & ~w_m1) | (i_d0 & w_m0 & ~w_m1) | (i_d1 & w_m1);

endmodule

// File: rtl/mp_ooo_dp_sram_init.sv
// Two-port single-clock SRAM stand-in with reset-time init sweep, masked writes and forwarding.
module mp_ooo_dp_sram_init
    import mp_ooo_sram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 2,
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    WMASK_GRAN = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter bit                    FWD_EN     = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             ready,
    input  logic                             csb0,
    input  logic                             web0,
    input  logic [DATA_WIDTH/WMASK_GRAN-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]            addr0,
    input  logic [DATA_WIDTH-1:0]            din0,
    output logic [DATA_WIDTH-1:0]            dout0,
    input  logic                             csb1,
    input  logic                             web1,
    input  logic [DATA_WIDTH/WMASK_GRAN-1:0] wmask1,
    input  logic [ADDR_WIDTH-1:0]            addr1,
    input  logic [DATA_WIDTH-1:0]            din1,
    output logic [DATA_WIDTH-1:0]            dout1
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    sram_init_state_t      r_state;
    logic [ADDR_WIDTH:0]   r_init_cnt;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_dout0;
    logic [DATA_WIDTH-1:0] r_dout1;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_run;
    logic                  w_we0;
    logic                  w_we1;
    logic                  w_re0;
    logic                  w_re1;
    logic                  w_same;
    logic [DATA_WIDTH-1:0] w_bm0;
    logic [DATA_WIDTH-1:0] w_bm1;
    logic [DATA_WIDTH-1:0] w_new0;
    logic [DATA_WIDTH-1:0] w_new1;

    assign w_run  = (r_state == SRAM_RUN);
    assign w_we0  = w_run & ~csb0 & ~web0;
    assign w_we1  = w_run & ~csb1 & ~web1;
    assign w_re0  = w_run & ~csb0 &  web0;
    assign w_re1  = w_run & ~csb1 &  web1;
    assign w_same = (addr0 == addr1);
    assign w_bm0  = DATA_WIDTH'(expand_wmask(SRAM_MAX_W'(wmask0), WMASK_GRAN));
    assign w_bm1  = DATA_WIDTH'(expand_wmask(SRAM_MAX_W'(wmask1), WMASK_GRAN));

    // The post-write word at each port's address: it is both the array update value and the
    // forwarded read value, since a reading port contributes no write of its own.
    mp_ooo_sram_wmerge #(.DATA_WIDTH(DATA_WIDTH)) u_merge0 (
        .i_old (r_mem[addr0]),
        .i_d0  (din0),
        .i_m0  (w_bm0),
        .i_en0 (w_we0),
        .i_d1  (din1),
        .i_m1  (w_bm1),
        .i_en1 (w_we1 & w_same),
        .o_new (w_new0)
    );

    mp_ooo_sram_wmerge #(.DATA_WIDTH(DATA_WIDTH)) u_merge1 (
        .i_old (r_mem[addr1]),
        .i_d0  (din0),
        .i_m0  (w_bm0),
        .i_en0 (w_we0 & w_same),
        .i_d1  (din1),
        .i_m1  (w_bm1),
        .i_en1 (w_we1),
        .o_new (w_new1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SRAM_INIT;
            r_init_cnt <= '0;
            r_ready    <= 1'b0;
            r_dout0    <= '0;
            r_dout1    <= '0;
        end else begin
            case (r_state)
                SRAM_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    r_dout0    <= '0;
                    r_dout1    <= '0;
                    if (r_init_cnt == (ADDR_WIDTH+1)'(DEPTH - 1)) begin
                        r_state <= SRAM_RUN;
                        r_ready <= 1'b1;
                    end
                end
                SRAM_RUN: begin
                    if (w_re0) r_dout0 <= FWD_EN ? w_new0 : r_mem[addr0];
                    if (w_re1) r_dout1 <= FWD_EN ? w_new1 : r_mem[addr1];
                end
                default: r_state <= SRAM_INIT;
            endcase
        end
    end

    // On a same-address double write both merges yield the same word, so write order is moot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == SRAM_INIT) begin
                r_mem[r_init_cnt[ADDR_WIDTH-1:0]] <= INIT_VALUE;
            end else begin
                if (w_we0) r_mem[addr0] <= w_new0;
                if (w_we1) r_mem[addr1] <= w_new1;
            end
        end
    end

    assign ready = r_ready;
    assign dout0 = r_dout0;
    assign dout1 = r_dout1;

endmodule

// File: tb/tb_mp_ooo_dp_sram_init.sv
// Directed bench: forwarding and non-forwarding 32x2 instances plus a 32x8 nibble-masked instance.
module tb_mp_ooo_dp_sram_init;

    logic       clk = 1'b0;
    logic       rst;
    logic       csb0, web0, csb1, web1;
    logic [1:0] wmask0, wmask1, din0, din1;
    logic [4:0] addr0, addr1;
    logic       rdy_a, rdy_b, rdy_c;
    logic [1:0] dout_a0, dout_a1, dout_b0, dout_b1;

    logic       c_csb0, c_web0, c_csb1, c_web1;
    logic [1:0] c_wm0, c_wm1;
    logic [4:0] c_addr0, c_addr1;
    logic [7:0] c_din0, c_din1, c_dout0, c_dout1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mp_ooo_dp_sram_init #(.DATA_WIDTH(2), .ADDR_WIDTH(5), .WMASK_GRAN(1),
                          .INIT_VALUE(2'b01), .FWD_EN(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .ready(rdy_a),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout_a0),
        .csb1(csb1), .web1(web1), .wmask1(wmask1), .addr1(addr1), .din1(din1), .dout1(dout_a1)
    );

    mp_ooo_dp_sram_init #(.DATA_WIDTH(2), .ADDR_WIDTH(5), .WMASK_GRAN(1),
                          .INIT_VALUE(2'b01), .FWD_EN(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .ready(rdy_b),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout_b0),
        .csb1(csb1), .web1(web1), .wmask1(wmask1), .addr1(addr1), .din1(din1), .dout1(dout_b1)
    );

    mp_ooo_dp_sram_init #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .WMASK_GRAN(4),
                          .INIT_VALUE(8'h5A), .FWD_EN(1'b1)) u_dut_c (
        .clk(clk), .rst(rst), .ready(rdy_c),
        .csb0(c_csb0), .web0(c_web0), .wmask0(c_wm0), .addr0(c_addr0), .din0(c_din0), .dout0(c_dout0),
        .csb1(c_csb1), .web1(c_web1), .wmask1(c_wm1), .addr1(c_addr1), .din1(c_din1), .dout1(c_dout1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic p0(input logic cs, input logic we, input logic [4:0] a,
                      input logic [1:0] d, input logic [1:0] m);
        csb0 = cs; web0 = we; addr0 = a; din0 = d; wmask0 = m;
    endtask

    task automatic p1(input logic cs, input logic we, input logic [4:0] a,
                      input logic [1:0] d, input logic [1:0] m);
        csb1 = cs; web1 = we; addr1 = a; din1 = d; wmask1 = m;
    endtask

    task automatic c0(input logic cs, input logic we, input logic [4:0] a,
                      input logic [7:0] d, input logic [1:0] m);
        c_csb0 = cs; c_web0 = we; c_addr0 = a; c_din0 = d; c_wm0 = m;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        p0(1'b1, 1'b1, 5'd0, 2'b00, 2'b00);
        p1(1'b1, 1'b1, 5'd0, 2'b00, 2'b00);
        c0(1'b1, 1'b1, 5'd0, 8'h00, 2'b00);
        c_csb1 = 1'b1; c_web1 = 1'b1; c_addr1 = '0; c_din1 = '0; c_wm1 = '0;
        tick();
        tick();
        chk("rst_ready", 32'(rdy_a), 32'd0);
        chk("rst_dout0", 32'(dout_a0), 32'd0);
        chk("rst_dout1", 32'(dout_a1), 32'd0);

        // Init sweep: ready must rise on exactly the 32nd edge after reset release.
        rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rdy_a && n < 40);
        chk("init_cycles", 32'(n), 32'd32);
        chk("init_ready_b", 32'(rdy_b), 32'd1);
        chk("init_ready_c", 32'(rdy_c), 32'd1);

        for (int a = 0; a < 32; a++) begin
            p0(1'b0, 1'b1, 5'(a), 2'b00, 2'b00);
            p1(1'b0, 1'b1, 5'(31 - a), 2'b00, 2'b00);
            tick();
            chk("init_rd0", 32'(dout_a0), 32'h1);
            chk("init_rd1", 32'(dout_a1), 32'h1);
        end

        // Write then read on the other port; a write leaves that port's dout alone.
        p1(1'b1, 1'b1, 5'd0, 2'b00, 2'b00);
        p0(1'b0, 1'b0, 5'd5, 2'b10, 2'b11);
        tick();
        chk("wr_hold_dout0", 32'(dout_a0), 32'h1);
        p0(1'b1, 1'b1, 5'd0, 2'b00, 2'b00);
        p1(1'b0, 1'b1, 5'd5, 2'b00, 2'b00);
        tick();
        chk("wr_then_rd", 32'(dout_a1), 32'h2);

        // Write-write collisions on addr 7.
        p0(1'b0, 1'b0, 5'd7, 2'b11, 2'b11);
        p1(1'b0, 1'b0, 5'd7, 2'b00, 2'b11);
        tick();
        p1(1'b1, 1'b1, 5'd0, 2'b00, 2'b00);
        p0(1'b0, 1'b1, 5'd7, 2'b00, 2'b00);
        tick();
        chk("ww_full", 32'(dout_a0), 32'h0);
        p0(1'b0, 1'b0, 5'd7, 2'b11, 2'b11);
        p1(1'b0, 1'b0, 5'd7, 2'b00, 2'b01);
        tick();
        p1(1'b1, 1'b1, 5'd0, 2'b00, 2'b00);
        p0(1'b0, 1'b1, 5'd7, 2'b00, 2'b00);
        tick();
        chk("ww_partial", 32'(dout_a0), 32'h2);
        p0(1'b0, 1'b0, 5'd7, 2'b11, 2'b01);
        tick();
        p0(1'b0, 1'b1, 5'd7, 2'b00, 2'b00);
        tick();
        chk("wr_lane0_only", 32'(dout_a0), 32'h3);

        // Read-write collisions on addr 3: A forwards, B returns the pre-write word.
        p0(1'b0, 1'b0, 5'd3, 2'b01, 2'b11);
        tick();
        p0(1'b0, 1'b0, 5'd3, 2'b10, 2'b11);
        p1(1'b0, 1'b1, 5'd3, 2'b00, 2'b00);
        tick();
        chk("rw_fwd_p1", 32'(dout_a1), 32'h2);
        chk("rw_nofwd_p1", 32'(dout_b1), 32'h1);
        p0(1'b0, 1'b1, 5'd3, 2'b00, 2'b00);
        p1(1'b0, 1'b0, 5'd3, 2'b01, 2'b01);
        tick();
        chk("rw_fwd_p0", 32'(dout_a0), 32'h3);
        chk("rw_nofwd_p0", 32'(dout_b0), 32'h2);
        p1(1'b1, 1'b1, 5'd0, 2'b00, 2'b00);
        tick();
        chk("rw_after_b", 32'(dout_b0), 32'h3);

        // Read-read on the same address.
        p0(1'b0, 1'b1, 5'd5, 2'b00, 2'b00);
        p1(1'b0, 1'b1, 5'd5, 2'b00, 2'b00);
        tick();
        chk("rr_p0", 32'(dout_a0), 32'h2);
        chk("rr_p1", 32'(dout_a1), 32'h2);

        // Nibble-masked instance.
        p0(1'b1, 1'b1, 5'd0, 2'b00, 2'b00);
        p1(1'b1, 1'b1, 5'd0, 2'b00, 2'b00);
        c0(1'b0, 1'b1, 5'd31, 8'h00, 2'b00);
        tick();
        chk("c_init", 32'(c_dout0), 32'h5A);
        c0(1'b0, 1'b0, 5'd0, 8'hA5, 2'b11);
        tick();
        c0(1'b0, 1'b0, 5'd0, 8'h3C, 2'b10);
        tick();
        c0(1'b0, 1'b1, 5'd0, 8'h00, 2'b00);
        tick();
        chk("c_masked", 32'(c_dout0), 32'h35);
        c0(1'b1, 1'b1, 5'd31, 8'hFF, 2'b11);
        tick();
        tick();
        chk("c_csb_hold", 32'(c_dout0), 32'h35);
        c0(1'b0, 1'b0, 5'd1, 8'hFF, 2'b11);
        tick();
        chk("c_wr_hold", 32'(c_dout0), 32'h35);
        c0(1'b1, 1'b1, 5'd0, 8'h00, 2'b00);

        // Reset at the RUN point of a write, then a write held across the whole sweep.
        p0(1'b0, 1'b0, 5'd9, 2'b10, 2'b11);
        rst = 1'b1;
        tick();
        chk("rrst_ready", 32'(rdy_a), 32'd0);
        chk("rrst_dout0", 32'(dout_a0), 32'd0);
        chk("rrst_dout1", 32'(dout_a1), 32'd0);
        rst = 1'b0;
        p0(1'b0, 1'b0, 5'd2, 2'b10, 2'b11);
        p1(1'b0, 1'b1, 5'd2, 2'b00, 2'b00);
        n = 0;
        do begin
            tick();
            n++;
        end while (!rdy_a && n < 40);
        chk("reinit_cycles", 32'(n), 32'd32);
        chk("reinit_dout0", 32'(dout_a0), 32'd0);
        chk("reinit_dout1", 32'(dout_a1), 32'd0);
        p1(1'b1, 1'b1, 5'd0, 2'b00, 2'b00);
        for (int a = 0; a < 32; a++) begin
            p0(1'b0, 1'b1, 5'(a), 2'b00, 2'b00);
            tick();
            chk("reinit_rd_a", 32'(dout_a0), 32'h1);
            chk("reinit_rd_b", 32'(dout_b0), 32'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
